align_operands: RTL and testbench
=================================

Name: align_operands

Overview:
- Alignment stage ahead of the big ALU; the counterpart of the sum normaliser.
- Accepts two IEEE754 single-precision operands and unpacks them into 32-bit fraction fields: bit 23 is the hidden bit, bits 31:24 are zero.
- Orders the operands by magnitude, then shifts the smaller fraction right by the exponent difference, iteratively over several cycles.
- Hands both aligned fractions plus the common exponent to the adder over a valid/ready handshake.

Parameters:
- SHIFT_STEP, 1: maximum right-shift applied per SHIFT cycle. Legal range 1..26.
- MAX_SHIFT, 25: if the exponent difference exceeds this, the small fraction is forced to 0 without iterating.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept a pair.
- a_in  input  32  IEEE754 operand A.
- b_in  input  32  IEEE754 operand B.
- op_in  input  1  0 = add, 1 = subtract; passed through.
- out_valid  output  1  aligned result present.
- out_ready  input  1  consumer accepts the result.
- frac_large  output  32  fraction of the larger-magnitude operand.
- frac_small  output  32  aligned fraction of the smaller operand.
- exponent_out  output  8  exponent of the larger operand.
- sign_large  output  1  sign of the larger operand.
- sign_small  output  1  sign of the smaller operand.
- op_out  output  1  registered op_in.
- swapped  output  1  1 when B was the larger operand.
- sticky_out  output  1  see Optional Feature.

Behaviour:
- Reset, asynchronous, any state:
  - state goes to IDLE.
  - All outputs go to 0, except in_ready, which is 1.
  - Any in-flight operation is discarded.
- States are IDLE, SHIFT and DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready, unpack both operands.
  - Exponent field 0 (denormal): hidden bit 0, effective exponent 1.
  - Otherwise: hidden bit 1, effective exponent = field.
  - Compare magnitudes as {eff_exp, frac}. B is larger only if strictly greater; ties keep A as large and swapped = 0.
  - Register large/small fraction, signs, exponent_out = large eff_exp, op_out, swapped.
  - Register remaining shift count diff = eff_exp_large - eff_exp_small (8-bit, never negative).
- Next state after accept:
  - diff == 0: go to DONE.
  - diff > MAX_SHIFT: frac_small = 0, go to DONE.
  - Otherwise: go to SHIFT.
- SHIFT, each cycle:
  - step = min(SHIFT_STEP, remaining).
  - frac_small >>= step; remaining -= step.
  - When remaining reaches 0, go to DONE.
- Latency, accept to out_valid: 1 cycle if diff == 0 or diff > MAX_SHIFT; otherwise 1 + ceil(diff / SHIFT_STEP) cycles.
- DONE:
  - All outputs are held stable while out_ready is low.
  - On out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle re-accept.
- in_valid is ignored outside IDLE.
- exponent_out is never modified by this block. NaN/Inf receive no special handling; they are treated as exponent 255.

Optional Feature:
- Macro: ALIGN_STICKY_EN.
- When defined:
  - sticky_out accumulates the OR of every 1-bit shifted out of frac_small, including the full fraction when the MAX_SHIFT bypass is taken.
  - sticky_out is cleared on each accept.
  - sticky_out is valid with out_valid.
- When undefined: sticky_out is tied to 0 and no accumulation logic is present.

Test Plan:
1. a=0x40400000, b=0x3F800000, SHIFT_STEP=1, out_ready=1 -> out_valid 2 cycles after accept; frac_large=0x00C00000, frac_small=0x00400000, exponent_out=128, swapped=0, sticky_out=0.
2. a=0x3F800000, b=0x40400000 -> same fractions and exponent, swapped=1, sign_large=0.
3. a=0x3FC00000, b=0x3F800000 -> out_valid 1 cycle after accept; frac_large=0x00C00000, frac_small=0x00800000, exponent_out=127.
4. a=0x4E800000, b=0x3F800001 (diff 30) -> out_valid 1 cycle after accept; frac_small=0; sticky_out=1 with ALIGN_STICKY_EN, 0 without.
5. Test 1 with out_ready held low 5 cycles -> outputs unchanged, in_ready=0, a new in_valid pulse ignored; release -> one transfer, then in_ready=1.
6. rst_n low mid-SHIFT (diff 20) -> all outputs 0 immediately, in_ready=1 after release; next pair processes correctly.

Source files
------------

// File: rtl/align_operands.sv
// rtl/align_operands.sv - IEEE754 single-precision operand alignment ahead of the adder.
// Optional sticky accumulation of shifted-out bits is enabled by defining ALIGN_STICKY_EN.
module align_operands #(
  parameter int SHIFT_STEP = 1,
  parameter int MAX_SHIFT  = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic        op_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] frac_large,
  output logic [31:0] frac_small,
  output logic [7:0]  exponent_out,
  output logic        sign_large,
  output logic        sign_small,
  output logic        op_out,
  output logic        swapped,
  output logic        sticky_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] STEP_W = 8'(SHIFT_STEP);
  localparam logic [7:0] MAX_W  = 8'(MAX_SHIFT);

  state_t      state;
  logic [7:0]  remaining;

  logic [7:0]  a_exp_eff;
  logic [7:0]  b_exp_eff;
  logic [31:0] a_frac;
  logic [31:0] b_frac;
  logic        b_larger;
  logic [7:0]  diff_in;
  logic [31:0] small_in;
  logic [7:0]  step;
  logic [31:0] shifted;
  logic        accept;

  // Denormals get hidden bit 0 and effective exponent 1; NaN/Inf are just exponent 255.
  always_comb begin
    a_exp_eff = (a_in[30:23] == 8'd0) ? 8'd1 : a_in[30:23];
    b_exp_eff = (b_in[30:23] == 8'd0) ? 8'd1 : b_in[30:23];
    a_frac    = {8'd0, (a_in[30:23] != 8'd0), a_in[22:0]};
    b_frac    = {8'd0, (b_in[30:23] != 8'd0), b_in[22:0]};
    b_larger  = {b_exp_eff, b_frac[23:0]} > {a_exp_eff, a_frac[23:0]};
    diff_in   = b_larger ? (b_exp_eff - a_exp_eff) : (a_exp_eff - b_exp_eff);
    small_in  = b_larger ? a_frac : b_frac;
    step      = (remaining < STEP_W) ? remaining : STEP_W;
    shifted   = frac_small >> step;
  end

  assign accept    = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= 8'd0;
      frac_large   <= 32'd0;
      frac_small   <= 32'd0;
      exponent_out <= 8'd0;
      sign_large   <= 1'b0;
      sign_small   <= 1'b0;
      op_out       <= 1'b0;
      swapped      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            frac_large   <= b_larger ? b_frac : a_frac;
            sign_large   <= b_larger ? b_in[31] : a_in[31];
            sign_small   <= b_larger ? a_in[31] : b_in[31];
            exponent_out <= b_larger ? b_exp_eff : a_exp_eff;
            op_out       <= op_in;
            swapped      <= b_larger;
            if (diff_in == 8'd0) begin
              frac_small <= small_in;
              remaining  <= 8'd0;
              state      <= DONE;
            end else if (diff_in > MAX_W) begin
              // Too far apart for any bit to survive: skip the iteration entirely.
              frac_small <= 32'd0;
              remaining  <= 8'd0;
              state      <= DONE;
            end else begin
              frac_small <= small_in;
              remaining  <= diff_in;
              state      <= SHIFT;
            end
          end
        end
        SHIFT: begin
          frac_small <= shifted;
          remaining  <= remaining - step;
          if (remaining == step) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALIGN_STICKY_EN
  logic        sticky;
  logic [31:0] lost_mask;

  assign lost_mask = (32'd1 << step) - 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
    end else if (accept) begin
      sticky <= (diff_in > MAX_W) ? (|small_in) : 1'b0;
    end else if (state == SHIFT) begin
      sticky <= sticky | (|(frac_small & lost_mask));
    end
  end

  assign sticky_out = sticky;
`else
  assign sticky_out = 1'b0;
`endif

endmodule

// File: tb/tb_align_operands.sv
// tb/tb_align_operands.sv - directed table-driven bench for align_operands.
module tb_align_operands;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        op_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] frac_large;
  logic [31:0] frac_small;
  logic [7:0]  exponent_out;
  logic        sign_large;
  logic        sign_small;
  logic        op_out;
  logic        swapped;
  logic        sticky_out;

  int checks;
  int failures;

`ifdef ALIGN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] fl;
    logic [31:0] fs;
    logic [7:0]  e;
    logic        sl;
    logic        ss;
    logic        sw;
    logic        st;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  align_operands #(.SHIFT_STEP(1), .MAX_SHIFT(25)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .frac_large(frac_large), .frac_small(frac_small),
    .exponent_out(exponent_out),
    .sign_large(sign_large), .sign_small(sign_small),
    .op_out(op_out), .swapped(swapped), .sticky_out(sticky_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t v, input string tag);
    check({tag, ".frac_large"}, frac_large, v.fl);
    check({tag, ".frac_small"}, frac_small, v.fs);
    check({tag, ".exponent"}, 32'(exponent_out), 32'(v.e));
    check({tag, ".sign_large"}, 32'(sign_large), 32'(v.sl));
    check({tag, ".sign_small"}, 32'(sign_small), 32'(v.ss));
    check({tag, ".swapped"}, 32'(swapped), 32'(v.sw));
    check({tag, ".op_out"}, 32'(op_out), 32'(v.op));
    check({tag, ".sticky"}, 32'(sticky_out), 32'(v.st));
  endtask

  // Drive one pair, measure accept-to-out_valid latency and leave the DUT in DONE.
  task automatic issue(input vec_t v, input string tag);
    int cyc;
    @(negedge clk);
    a_in = v.a; b_in = v.b; op_in = v.op; in_valid = 1'b1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(v.lat));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    issue(v, tag);
    check_outputs(v, tag);
    @(posedge clk); #1;
    check({tag, ".after_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".after_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = 1'b0; out_ready = 1'b1;

    vecs[0] = '{32'h40400000, 32'h3F800000, 1'b0, 32'h00C00000, 32'h00400000, 8'd128, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[1] = '{32'h3F800000, 32'h40400000, 1'b1, 32'h00C00000, 32'h00400000, 8'd128, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[2] = '{32'h3FC00000, 32'h3F800000, 1'b0, 32'h00C00000, 32'h00800000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[3] = '{32'h4E800000, 32'h3F800001, 1'b0, 32'h00800000, 32'h00000000, 8'd157, 1'b0, 1'b0, 1'b0, STK, 1};
    vecs[4] = '{32'hC0000000, 32'h40000000, 1'b1, 32'h00800000, 32'h00800000, 8'd128, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[5] = '{32'h00000001, 32'h00800000, 1'b0, 32'h00800000, 32'h00000001, 8'd1,   1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[6] = '{32'h41000000, 32'hBF800007, 1'b1, 32'h00800000, 32'h00100000, 8'd130, 1'b0, 1'b1, 1'b0, STK, 4};
    vecs[7] = '{32'h4C000000, 32'h3F800000, 1'b0, 32'h00800000, 32'h00000000, 8'd152, 1'b0, 1'b0, 1'b0, STK, 26};
    vecs[8] = '{32'h4C800000, 32'h3F800000, 1'b0, 32'h00800000, 32'h00000000, 8'd153, 1'b0, 1'b0, 1'b0, STK, 1};
    vecs[9] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h00800000, 32'h00000000, 8'd255, 1'b0, 1'b0, 1'b0, STK, 1};

    #12;
    check("reset.in_ready", 32'(in_ready), 32'd1);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.frac_large", frac_large, 32'd0);
    check("reset.exponent", 32'(exponent_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: result must hold while out_ready is low and new pairs are ignored.
    out_ready = 1'b0;
    issue(vecs[0], "hold");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_in = 32'h3F800000; b_in = 32'h4E800000; in_valid = (k == 2);
      check($sformatf("hold%0d.in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("hold%0d.out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d.frac_small", k), frac_small, 32'h00400000);
      check($sformatf("hold%0d.exponent", k), 32'(exponent_out), 32'd128);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold.release_out_valid", 32'(out_valid), 32'd0);
    check("hold.release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("hold.no_ghost_accept", 32'(in_ready), 32'd1);

    // Asynchronous reset in the middle of a 20-step shift.
    @(negedge clk);
    a_in = 32'h49800000; b_in = 32'h3F800000; op_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midshift.busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.frac_large", frac_large, 32'd0);
    check("rst.frac_small", frac_small, 32'd0);
    check("rst.exponent", 32'(exponent_out), 32'd0);
    check("rst.flags", {26'd0, sign_large, sign_small, op_out, swapped, sticky_out, 1'b0}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_vec(vecs[1], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
